// File: rtl/sdr_pkg.sv
// Shared SDR datapath definitions.
//   IQ_IN_W / IQ_OUT_W : default component widths at the delay-line output and after packing.
//   iq_in_t / iq_out_t : {I,Q} sample layouts at each width, with I in the upper half.
//   rnd_bias()         : half-LSB bias for round-half-up when narrowing in_w -> out_w bits.
//   sat_max/sat_min()  : two's-complement limits of a w-bit signed value.
package sdr_pkg;

    localparam int IQ_IN_W  = 24;
    localparam int IQ_OUT_W = 16;

    typedef struct packed {
        logic signed [IQ_IN_W-1:0] i;
        logic signed [IQ_IN_W-1:0] q;
    } iq_in_t;

    typedef struct packed {
        logic signed [IQ_OUT_W-1:0] i;
        logic signed [IQ_OUT_W-1:0] q;
    } iq_out_t;

    function automatic int rnd_bias(input int in_w, input int out_w);
        return (in_w > out_w) ? (1 << (in_w - out_w - 1)) : 0;
    endfunction

    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/sdr_sync_fifo.sv
// Single-clock show-ahead FIFO. rd_data_o always shows the head entry while the FIFO
// is not empty. A write to a full FIFO is accepted when a read happens in the same cycle.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset (clears pointers and level)
//   wr_en_i       : write request, wr_data_i [WIDTH-1:0]
//   rd_en_i       : pop the head entry, rd_data_o [WIDTH-1:0]
//   full_o        : level == DEPTH
//   empty_o       : level == 0
//   level_o       : occupancy, $clog2(DEPTH)+1 bits
module sdr_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
    logic [LVL_W-1:0] level_d, level_q;
    logic             wr_ok, rd_ok;

    assign full_o    = (level_q == LVL_W'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    assign rd_ok = rd_en_i & ~empty_o;
    // When full, the slot being written is the one being popped this cycle.
    assign wr_ok = wr_en_i & (~full_o | rd_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({wr_ok, rd_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/iq_packer.sv
// Output packer behind the 48-bit alignment delay line. Each signed I/Q component is
// rounded half-up from IN_W to OUT_W bits, the pair is packed into one word, buffered
// in a show-ahead FIFO and streamed out with a frame marker every FRAME_LEN words.
// Build option: define IQ_PACKER_SAT_EN to saturate rounded values to the OUT_W range;
// without it the rounded value wraps (keeps the low OUT_W bits).
// Ports:
//   clk_i, rst_i         : clock, synchronous active-high reset
//   data_i [2*IN_W]      : {I,Q} signed input sample, valid_i marks a new sample
//   m_data_o [2*OUT_W]   : {I_out,Q_out} head word, m_valid_o / m_ready_i handshake
//   m_last_o             : head word is the last of its frame
//   ovf_o / ovf_clr_i    : sticky "sample dropped on full FIFO" flag and its clear
//   level_o              : FIFO occupancy
module iq_packer
    import sdr_pkg::*;
#(
    parameter int IN_W       = IQ_IN_W,
    parameter int OUT_W      = IQ_OUT_W,
    parameter int FIFO_DEPTH = 16,
    parameter int FRAME_LEN  = 256
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [2*IN_W-1:0]             data_i,
    input  logic                          valid_i,
    output logic [2*OUT_W-1:0]            m_data_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic                          m_last_o,
    output logic                          ovf_o,
    input  logic                          ovf_clr_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int SHIFT = IN_W - OUT_W;
    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
    // One guard bit so adding the bias to the most positive input cannot overflow.
    localparam logic signed [IN_W:0] RND_BIAS = (IN_W+1)'(rnd_bias(IN_W, OUT_W));
`ifdef IQ_PACKER_SAT_EN
    localparam logic signed [IN_W:0] SAT_HI = (IN_W+1)'(sat_max(OUT_W));
    localparam logic signed [IN_W:0] SAT_LO = (IN_W+1)'(sat_min(OUT_W));
`endif

    function automatic logic signed [OUT_W-1:0] round_comp(input logic signed [IN_W-1:0] x);
        logic signed [IN_W:0] ext;
        logic signed [IN_W:0] shifted;
        ext     = (IN_W+1)'(x);
        shifted = (ext + RND_BIAS) >>> SHIFT;
`ifdef IQ_PACKER_SAT_EN
        if (shifted > SAT_HI)      return OUT_W'(SAT_HI);
        else if (shifted < SAT_LO) return OUT_W'(SAT_LO);
        else                       return OUT_W'(shifted);
`else
        return OUT_W'(shifted);
`endif
    endfunction

    logic signed [IN_W-1:0]  i_in, q_in;
    logic [2*OUT_W-1:0]      iq_p1_d, iq_p1_q;
    logic                    vld_p1_d, vld_p1_q;
    logic [2*OUT_W-1:0]      fifo_head;
    logic                    fifo_full, fifo_empty;
    logic                    rd_en, wr_en, drop;
    logic                    ovf_d, ovf_q;
    logic [CNT_W-1:0]        cnt_d, cnt_q;

    assign i_in = data_i[2*IN_W-1:IN_W];
    assign q_in = data_i[IN_W-1:0];

    // ---- stage 1: round/saturate register ----
    always_comb begin
        vld_p1_d = valid_i;
        iq_p1_d  = iq_p1_q;
        if (valid_i) iq_p1_d = {round_comp(i_in), round_comp(q_in)};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) vld_p1_q <= 1'b0;
        else       vld_p1_q <= vld_p1_d;
        iq_p1_q <= iq_p1_d;
    end

    // ---- stage 2: FIFO write, output stream, frame counter ----
    assign rd_en = m_ready_i & ~fifo_empty;
    assign wr_en = vld_p1_q & (~fifo_full | rd_en);
    assign drop  = vld_p1_q & ~wr_en;

    sdr_sync_fifo #(
        .WIDTH (2*OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (wr_en),
        .wr_data_i (iq_p1_q),
        .rd_en_i   (rd_en),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (level_o)
    );

    always_comb begin
        // A drop in the same cycle as a clear keeps the flag set.
        ovf_d = drop | (ovf_q & ~ovf_clr_i);
        cnt_d = cnt_q;
        if (rd_en) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
        end
    end

    // Data is forced to zero when idle so the unreset FIFO storage never shows through.
    assign m_valid_o = ~fifo_empty;
    assign m_data_o  = m_valid_o ? fifo_head : '0;
    assign m_last_o  = m_valid_o & (cnt_q == CNT_LAST);
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_iq_packer.sv
module tb_iq_packer;

    localparam int FIFO_DEPTH = 16;
    localparam int FRAME_LEN  = 4;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

`ifdef IQ_PACKER_SAT_EN
    localparam logic [15:0] POS_FULL = 16'h7FFF;
`else
    localparam logic [15:0] POS_FULL = 16'h8000;
`endif

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [47:0]      data_i;
    logic             valid_i;
    logic [31:0]      m_data_o;
    logic             m_valid_o;
    logic             m_ready_i;
    logic             m_last_o;
    logic             ovf_o;
    logic             ovf_clr_i;
    logic [LVL_W-1:0] level_o;

    int n_checks = 0;
    int n_errors = 0;

    iq_packer #(
        .IN_W       (24),
        .OUT_W      (16),
        .FIFO_DEPTH (FIFO_DEPTH),
        .FRAME_LEN  (FRAME_LEN)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .m_data_o  (m_data_o),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_last_o  (m_last_o),
        .ovf_o     (ovf_o),
        .ovf_clr_i (ovf_clr_i),
        .level_o   (level_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Sample k: I = k*256, Q = -k*256, so both round exactly to +k / -k.
    function automatic logic [47:0] sample(input int k);
        logic [23:0] iv, qv;
        iv = 24'(k * 256);
        qv = 24'(-(k * 256));
        return {iv, qv};
    endfunction

    function automatic logic [31:0] word(input int k);
        logic [15:0] a, b;
        a = 16'(k);
        b = 16'(-k);
        return {a, b};
    endfunction

    task automatic do_reset;
        rst_i     = 1'b1;
        valid_i   = 1'b0;
        m_ready_i = 1'b0;
        ovf_clr_i = 1'b0;
        tick;
        tick;
        rst_i = 1'b0;
    endtask

    task automatic one_sample(input string tag, input logic [47:0] d, input logic [31:0] exp);
        data_i    = d;
        valid_i   = 1'b1;
        m_ready_i = 1'b1;
        tick;
        valid_i = 1'b0;
        check({tag, "_early"}, 64'(m_valid_o), 64'(1'b0));
        tick;
        check({tag, "_valid"}, 64'(m_valid_o), 64'(1'b1));
        check({tag, "_data"}, 64'(m_data_o), 64'(exp));
        tick;
        check({tag, "_gone"}, 64'(m_valid_o), 64'(1'b0));
    endtask

    task automatic drain_check(input string tag, input int n, input int first, input int fpos);
        int got = 0;
        m_ready_i = 1'b1;
        for (int c = 0; c < n + 6; c++) begin
            if (m_valid_o) begin
                check({tag, "_data"}, 64'(m_data_o), 64'(word(first + got)));
                check({tag, "_last"}, 64'(m_last_o),
                      64'(((fpos + got) % FRAME_LEN) == FRAME_LEN - 1));
                got++;
            end
            tick;
        end
        check({tag, "_count"}, 64'(got), 64'(n));
    endtask

    initial begin
        int rd;
        logic [39:0] rdy_pat;

        // Reset state
        rst_i = 1'b1; valid_i = 1'b0; m_ready_i = 1'b0; ovf_clr_i = 1'b0; data_i = '0;
        tick;
        tick;
        check("rst_valid", 64'(m_valid_o), 64'(1'b0));
        check("rst_last",  64'(m_last_o),  64'(1'b0));
        check("rst_data",  64'(m_data_o),  64'(0));
        check("rst_ovf",   64'(ovf_o),     64'(1'b0));
        check("rst_level", 64'(level_o),   64'(0));
        rst_i = 1'b0;
        tick;

        // Rounding and saturation vectors
        one_sample("rnd_basic",  {24'h000180, 24'hFFFE80}, 32'h0002FFFF);
        one_sample("sat_ipos",   {24'h7FFFFF, 24'h800000}, {POS_FULL, 16'h8000});
        one_sample("sat_qpos",   {24'h800000, 24'h7FFFFF}, {16'h8000, POS_FULL});
        one_sample("rnd_half",   {24'h000080, 24'h00007F}, 32'h00010000);
        one_sample("rnd_neg",    {24'hFFFF80, 24'hFFFF7F}, 32'h0000FFFF);

        // Overflow: 20 samples into a stalled 16-deep FIFO
        do_reset;
        for (int k = 1; k <= 20; k++) begin
            data_i  = sample(k);
            valid_i = 1'b1;
            tick;
        end
        valid_i = 1'b0;
        tick;
        tick;
        check("ovf_level", 64'(level_o),   64'(16));
        check("ovf_flag",  64'(ovf_o),     64'(1'b1));
        check("ovf_head",  64'(m_data_o),  64'(word(1)));
        drain_check("ovf_drain", 16, 1, 0);
        check("ovf_empty",  64'(level_o), 64'(0));
        check("ovf_sticky", 64'(ovf_o),   64'(1'b1));
        ovf_clr_i = 1'b1;
        tick;
        ovf_clr_i = 1'b0;
        check("ovf_clr", 64'(ovf_o), 64'(1'b0));

        // Full FIFO with continuous input and ready: read+write in the same cycle
        do_reset;
        rd = 0;
        for (int n = 0; n < 30; n++) begin
            data_i    = sample(n + 1);
            valid_i   = 1'b1;
            m_ready_i = (n >= 17);
            if (m_ready_i && m_valid_o) begin
                check("full_rw_data", 64'(m_data_o), 64'(word(rd + 1)));
                rd++;
            end
            if (n >= 17) begin
                check("full_rw_level", 64'(level_o), 64'(16));
                check("full_rw_ovf",   64'(ovf_o),   64'(1'b0));
            end
            tick;
        end
        valid_i   = 1'b0;
        m_ready_i = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (m_valid_o) begin
                check("full_rw_data", 64'(m_data_o), 64'(word(rd + 1)));
                rd++;
            end
            tick;
        end
        check("full_rw_count", 64'(rd),    64'(30));
        check("full_rw_ovf_end", 64'(ovf_o), 64'(1'b0));

        // Frames of 4 with ready stalls
        do_reset;
        rd = 0;
        rdy_pat = 40'b1011_0010_1101_0011_1001_0110_1100_1010_0111_0101;
        for (int c = 0; c < 80; c++) begin
            if (c < 10) begin
                data_i  = sample(c + 1);
                valid_i = 1'b1;
            end else begin
                valid_i = 1'b0;
            end
            m_ready_i = rdy_pat[c % 40];
            if (m_valid_o) begin
                check("frame_data", 64'(m_data_o), 64'(word(rd + 1)));
                check("frame_last", 64'(m_last_o), 64'((rd % FRAME_LEN) == FRAME_LEN - 1));
                if (m_ready_i) rd++;
            end
            tick;
        end
        check("frame_count", 64'(rd), 64'(10));

        // Reset mid-frame with 5 buffered words (frame position is 2 here)
        m_ready_i = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            data_i  = sample(k);
            valid_i = 1'b1;
            tick;
        end
        valid_i = 1'b0;
        tick;
        tick;
        check("midrst_level_pre", 64'(level_o), 64'(5));
        rst_i = 1'b1;
        tick;
        rst_i = 1'b0;
        check("midrst_valid", 64'(m_valid_o), 64'(1'b0));
        check("midrst_level", 64'(level_o),   64'(0));
        tick;
        tick;
        check("midrst_idle", 64'(m_valid_o), 64'(1'b0));
        for (int k = 11; k <= 14; k++) begin
            data_i  = sample(k);
            valid_i = 1'b1;
            tick;
        end
        valid_i = 1'b0;
        tick;
        tick;
        drain_check("midrst_frame", 4, 11, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/iq_packer.md
Name: iq_packer

Overview:
- Output stage that sits directly downstream of the 48-bit alignment delay line. It consumes the delay line's 48-bit aligned complex sample stream, with I in [47:24] and Q in [23:0], both signed.
- Each component is rounded from IN_W to OUT_W bits, and the pair is packed into one 2*OUT_W word.
- Packed words are buffered in a small FIFO and presented on a valid/ready stream, with a frame marker every FRAME_LEN words, toward the host/transport interface.

Parameters:
IN_W, 24, width of each I/Q component on data_i
OUT_W, 16, width of each I/Q component on m_data_o
FIFO_DEPTH, 16, FIFO entries; power of 2, >=4
FRAME_LEN, 256, output words per frame; >=2

Ports:
clk_i  input  1  single clock; all logic on rising edge
rst_i  input  1  reset, synchronous, active-high
data_i  input  2*IN_W  {I,Q} signed sample from delay line
valid_i  input  1  data_i holds a new sample this cycle
m_data_o  output  2*OUT_W  {I_out,Q_out} packed word
m_valid_o  output  1  m_data_o valid
m_ready_i  input  1  downstream accepts word
m_last_o  output  1  word is last of frame
ovf_o  output  1  sticky overflow: sample dropped on full FIFO
ovf_clr_i  input  1  clears ovf_o
level_o  output  clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset values: m_valid_o=0, m_last_o=0, m_data_o=0, ovf_o=0, level_o=0. Reset also clears the frame counter, the FIFO pointers and the stage-1 valid. Reset mid-frame discards all buffered words, and the frame restarts at word 0.
- Stage 1 (rounding register):
  - On valid_i=1, each component is rounded round-half-up: add 2^(IN_W-OUT_W-1), then arithmetic-shift right by IN_W-OUT_W.
  - The result is saturated per Optional Feature and registered with s1_valid.
  - There is no backpressure upstream; valid_i is never stalled.
- Stage 2 (FIFO write):
  - s1_valid writes the word when the FIFO is not full, or when it is full and a read handshake occurs in the same cycle. That simultaneous case is a legal write, and the level stays at FIFO_DEPTH.
  - Otherwise the word is dropped and ovf_o is set next cycle.
- Latency: a sample with valid_i at edge k is visible as m_valid_o=1 after edge k+2 when the FIFO is empty.
- FIFO is show-ahead: m_data_o is the head word whenever m_valid_o=1.
- Handshake rules:
  - Transfer occurs when m_valid_o & m_ready_i.
  - m_data_o and m_last_o hold stable while m_valid_o=1 & m_ready_i=0.
  - m_ready_i with the FIFO empty is a no-op.
- level_o: +1 on write without read, -1 on read without write, unchanged on both or neither.
- Frame counter (0..FRAME_LEN-1): increments on each transfer and wraps to 0 after FRAME_LEN-1. m_last_o = m_valid_o & (count==FRAME_LEN-1). Dropped samples do not advance the counter.
- ovf_o: ovf_clr_i clears it. If a set and a clear occur in the same cycle, the set wins.

Optional Feature:
- Macro: IQ_PACKER_SAT_EN.
- Defined: a rounded value above 2^(OUT_W-1)-1 clamps to 0x7FFF, and a value below -2^(OUT_W-1) clamps to 0x8000 (OUT_W=16).
- Undefined: the rounded value is truncated to OUT_W bits (two's-complement wrap), giving less logic.

Decomposition:
- Shared package sdr_pkg holds:
  - IQ_IN_W=24 and IQ_OUT_W=16;
  - the packed-sample typedef for {I,Q} at each width;
  - the round/saturate constant helpers.
- One sub-module, sdr_sync_fifo: parameterised width/depth, show-ahead, with wr_en/rd_en/full/empty/level. The frame counter and rounding logic stay in iq_packer.

Test Plan:
- Reset, then a single sample I=0x000180, Q=0xFFFE80, m_ready_i=1 -> after 2 cycles m_data_o=0x0002FFFF (I=0x0002 rounded up, Q=0xFFFF), m_valid_o for 1 cycle.
- I=0x7FFFFF -> with IQ_PACKER_SAT_EN, I_out=0x7FFF; without it, I_out=0x8000. I=0x800000 -> I_out=0x8000 in both builds.
- m_ready_i=0, 20 consecutive valid_i (FIFO_DEPTH=16) -> level_o=16, ovf_o=1, 4 samples dropped. After releasing ready, exactly 16 words come out in order. ovf_clr_i then clears ovf_o.
- FIFO full with continuous valid_i and m_ready_i=1 -> no drop, level_o stays 16, ovf_o stays 0.
- FRAME_LEN=4, 10 samples with random ready stalls -> m_last_o on words 4 and 8, and data stable during stalls.
- Assert rst_i while holding 5 buffered words mid-frame -> next cycle m_valid_o=0, level_o=0. The next sample starts at frame word 0.
